// File: rtl/fft_output_serializer.sv
// FFT output serializer: captures a 16-point complex frame from flat buses
// and streams it out one sample per accepted beat under valid/ready flow control.
module fft_output_serializer #(
  parameter int DATA_WIDTH  = 20,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*16-1:0]       x_in_flat_real,
  input  logic [DATA_WIDTH*16-1:0]       x_in_flat_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH-1:0]   out_real,
  output logic signed [DATA_WIDTH-1:0]   out_imag,
  output logic [3:0]                     out_index,
  output logic                           out_last,
  output logic [15:0]                    frame_count
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                        state_p0;
  state_t                        state_nxt;
  logic [3:0]                    cnt_p0;
  logic [3:0]                    cnt_nxt;
  logic [15:0]                   fcnt_p0;
  logic signed [DATA_WIDTH-1:0]  mem_real_p0 [16];
  logic signed [DATA_WIDTH-1:0]  mem_imag_p0 [16];
  logic                          capture;
  logic                          accept;
  logic                          last_beat;
  logic [3:0]                    rd_addr;

  function automatic logic [3:0] bit_rev4(input logic [3:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

  // A new frame may only land when the buffer is free or its final beat is leaving
  // this very cycle, which lets consecutive frames stream without a bubble.
  assign out_valid   = (state_p0 == STREAM);
  assign last_beat   = out_valid && (cnt_p0 == 4'd15);
  assign in_ready    = !rst && (!out_valid || (out_ready && last_beat));
  assign capture     = in_valid && in_ready;
  assign accept      = out_valid && out_ready;

  // Outputs read straight from the buffer; the buffer only reloads on capture,
  // so the presented sample stays put while downstream stalls.
  assign rd_addr     = BIT_REVERSE ? bit_rev4(cnt_p0) : cnt_p0;
  assign out_real    = mem_real_p0[rd_addr];
  assign out_imag    = mem_imag_p0[rd_addr];
  assign out_index   = cnt_p0;
  assign out_last    = last_beat;
  assign frame_count = fcnt_p0;

  // Next-state and beat counter logic
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    case (state_p0)
      IDLE: begin
        if (capture) begin
          state_nxt = STREAM;
          cnt_nxt   = 4'd0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (cnt_p0 == 4'd15) begin
            cnt_nxt   = 4'd0;
            state_nxt = capture ? STREAM : IDLE;
          end else begin
            cnt_nxt = cnt_p0 + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, beat counter and completed-frame counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= 4'd0;
      fcnt_p0  <= 16'd0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (accept && last_beat) begin
        fcnt_p0 <= fcnt_p0 + 16'd1;
      end
    end
  end

  // Frame buffer: cleared on reset, loaded from the flat buses on capture (sample 0 in MSBs)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_real_p0[i] <= '0;
        mem_imag_p0[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < 16; i++) begin
        mem_real_p0[i] <= x_in_flat_real[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
        mem_imag_p0[i] <= x_in_flat_imag[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench for fft_output_serializer: natural-order and bit-reversed instances.
module tb_fft_output_serializer;
  localparam int DW = 20;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [3:0]           idx;
    logic                 last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_valid_br = 1'b0;
  logic out_ready = 1'b1;
  logic [DW*16-1:0] flat_re = '0;
  logic [DW*16-1:0] flat_im = '0;

  logic in_ready, out_valid, out_last;
  logic signed [DW-1:0] out_real, out_imag;
  logic [3:0] out_index;
  logic [15:0] frame_count;

  logic in_ready_b, out_valid_b, out_last_b;
  logic signed [DW-1:0] out_real_b, out_imag_b;
  logic [3:0] out_index_b;
  logic [15:0] frame_count_b;

  exp_t q0[$];
  exp_t q1[$];
  logic signed [DW-1:0] fr_re [16];
  logic signed [DW-1:0] fr_im [16];
  int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mcyc = 0;
  int last_acc_cyc = -1000;
  int gap0 = 0;
  bit bp = 1'b0;

  always #5 clk = ~clk;

  fft_output_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in_flat_real(flat_re), .x_in_flat_imag(flat_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .frame_count(frame_count)
  );

  fft_output_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) dut_br (
    .clk(clk), .rst(rst), .in_valid(in_valid_br), .in_ready(in_ready_b),
    .x_in_flat_real(flat_re), .x_in_flat_imag(flat_im),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_real(out_real_b), .out_imag(out_imag_b), .out_index(out_index_b),
    .out_last(out_last_b), .frame_count(frame_count_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int qsize(input int id);
    return (id != 0) ? q1.size() : q0.size();
  endfunction

  // Monitor step for one instance: compare the presented beat with the queue head
  task automatic mon(input int id, input logic v, input logic rdy, input logic ir,
                     input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                     input logic [3:0] idx, input logic last);
    exp_t e;
    if (v) begin
      checks++;
      if (qsize(id) == 0) begin
        errors++;
        $display("FAIL beat_unexpected[%0d]: got idx=%0d re=%0d expected no beat", id, idx, re);
      end else begin
        e = (id != 0) ? q1[0] : q0[0];
        if ({re, im, idx, last} !== {e.re, e.im, e.idx, e.last}) begin
          errors++;
          $display("FAIL beat[%0d]: got re=%0d im=%0d idx=%0d last=%0d expected re=%0d im=%0d idx=%0d last=%0d",
                   id, re, im, idx, last, e.re, e.im, e.idx, e.last);
        end
        if (rdy) begin
          if (id != 0) void'(q1.pop_front());
          else begin
            void'(q0.pop_front());
            if (e.idx == 4'd0) gap0 = mcyc - last_acc_cyc;
            if (e.last) last_acc_cyc = mcyc;
          end
        end
      end
      if (!(rdy && last)) begin
        checks++;
        if (ir !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_busy[%0d]: got %0d expected 0", id, ir);
        end
      end
    end else if (!rst) begin
      checks++;
      if (ir !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_idle[%0d]: got %0d expected 1", id, ir);
      end
    end
  endtask

  // Output monitor, sampling away from the active edge
  always @(negedge clk) begin
    mcyc++;
    mon(0, out_valid, out_ready, in_ready, out_real, out_imag, out_index, out_last);
    mon(1, out_valid_b, out_ready, in_ready_b, out_real_b, out_imag_b, out_index_b, out_last_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  endtask

  // Load buses from fr_re/fr_im, queue expected beats, hold valid until captured
  task automatic send_frame(input int id);
    exp_t e;
    bit got;
    int k;
    for (int i = 0; i < 16; i++) begin
      flat_re[DW*(16-i)-1 -: DW] = fr_re[i];
      flat_im[DW*(16-i)-1 -: DW] = fr_im[i];
    end
    for (int b = 0; b < 16; b++) begin
      k = (id != 0) ? br_tab[b] : b;
      e.re = fr_re[k];
      e.im = fr_im[k];
      e.idx = 4'(b);
      e.last = (b == 15);
      if (id != 0) q1.push_back(e);
      else q0.push_back(e);
    end
    if (id != 0) in_valid_br = 1'b1;
    else in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = (id != 0) ? in_ready_b : in_ready;
      tick();
    end
    if (!got) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int id);
    int t;
    t = 0;
    while ((qsize(id) != 0 || ((id != 0) ? out_valid_b : out_valid)) && t < 400) begin
      tick();
      t++;
    end
    chk("drain_done", 32'(t < 400), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_real", 32'(out_real), 32'd0);
    chk("rst_out_imag", 32'(out_imag), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    tick();

    // Basic frame, ready held high
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(i + 1);
      fr_im[i] = -DW'(i + 1);
    end
    send_frame(0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_index", 32'(out_index), 32'd0);
    drain(0);
    chk("basic_frame_count", 32'(frame_count), 32'd1);

    // Backpressure 1,0,0,1
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(3 * i - 20);
      fr_im[i] = DW'(7 * i + 5);
    end
    bp = 1'b1;
    send_frame(0);
    in_valid = 1'b0;
    drain(0);
    bp = 1'b0;
    tick();
    chk("bp_frame_count", 32'(frame_count), 32'd2);

    // Back-to-back frames, in_valid held
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(i + 1);
      fr_im[i] = -DW'(i + 1);
    end
    send_frame(0);
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(100 + i);
      fr_im[i] = DW'(i);
    end
    send_frame(0);
    in_valid = 1'b0;
    drain(0);
    chk("b2b_gap", 32'(gap0), 32'd1);
    chk("b2b_frame_count", 32'(frame_count), 32'd4);

    // Signed extremes
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = (i % 2 == 0) ? -20'sd524288 : 20'sd524287;
      fr_im[i] = (i % 2 == 0) ? 20'sd524287 : -20'sd524288;
    end
    send_frame(0);
    in_valid = 1'b0;
    drain(0);
    chk("ext_frame_count", 32'(frame_count), 32'd5);

    // Bit-reversed order on the second instance
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(i);
      fr_im[i] = -DW'(i);
    end
    send_frame(1);
    in_valid_br = 1'b0;
    drain(1);
    chk("br_frame_count", 32'(frame_count_b), 32'd1);
    chk("br_other_count", 32'(frame_count), 32'd5);

    // Reset mid-frame after beat 5
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(50 + i);
      fr_im[i] = DW'(60 + i);
    end
    send_frame(0);
    in_valid = 1'b0;
    for (int t = 0; t < 100 && q0.size() > 10; t++) tick();
    chk("mid_beats_taken", 32'(q0.size()), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_frame_count", 32'(frame_count), 32'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = DW'(-i);
      fr_im[i] = DW'(200 + i);
    end
    send_frame(0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_index", 32'(out_index), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_count_start", 32'(frame_count), 32'd0);
    drain(0);
    chk("post_rst_frame_count", 32'(frame_count), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
